// File: rtl/register_file_sb_if.sv
// Read, write and issue signals of the scoreboarded register file.
// The master drives addresses, write data and issues; the slave returns read data and busy flags.
interface register_file_sb_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 2
);
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rd_busy;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic                issue_v;
  logic [AW-1:0]       issue_a;

  modport master (
    output ra, we, wa, wd, issue_v, issue_a,
    input  rd, rd_busy
  );

  modport slave (
    input  ra, we, wa, wd, issue_v, issue_a,
    output rd, rd_busy
  );
endinterface

// File: rtl/register_file_sb.sv
// Multi-port register file with a per-register busy scoreboard.
// It supports write-to-read bypass, a hardwired x0 and optional registered reads.
module register_file_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned READ_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  register_file_sb_if.slave bus
);

  logic [XLEN-1:0]     regs_q [NREG];
  logic [NREG-1:0]     busy_q, busy_d;
  logic                wr_en;
  logic [AW-1:0]       ra_p   [NRD];
  logic [NRD-1:0]      hit;
  logic [NRD*XLEN-1:0] rd_v;
  logic [NRD-1:0]      b_v;

  assign wr_en = bus.we && !(ZERO_REG != 0 && bus.wa == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < int'(NREG); r++) regs_q[r] <= '0;
      busy_q <= '0;
    end else begin
      if (wr_en) regs_q[bus.wa] <= bus.wd;
      busy_q <= busy_d;
    end
  end

  // A newly issued producer wins over the write that retires the previous one.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < int'(NREG); r++) begin
      if (bus.issue_v && bus.issue_a == AW'(r) && !(ZERO_REG != 0 && r == 0)) begin
        busy_d[r] = 1'b1;
      end else if (bus.we && bus.wa == AW'(r)) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  always_comb begin
    rd_v = '0;
    b_v  = '0;
    hit  = '0;
    for (int i = 0; i < int'(NRD); i++) begin
      ra_p[i] = bus.ra[i*AW +: AW];
      hit[i]  = BYPASS != 0 && bus.we && bus.wa == ra_p[i] &&
                !(ZERO_REG != 0 && ra_p[i] == '0);
      if (ZERO_REG != 0 && ra_p[i] == '0) begin
        rd_v[i*XLEN +: XLEN] = '0;
        b_v[i]               = 1'b0;
      end else if (hit[i]) begin
        // The forwarded write satisfies the old producer; only a same-cycle issue re-claims it.
        rd_v[i*XLEN +: XLEN] = bus.wd;
        b_v[i]               = bus.issue_v && bus.issue_a == ra_p[i];
      end else begin
        rd_v[i*XLEN +: XLEN] = regs_q[ra_p[i]];
        b_v[i]               = busy_q[ra_p[i]];
      end
    end
  end

  if (READ_REG != 0) begin : g_reg
    logic [NRD*XLEN-1:0] rd_q;
    logic [NRD-1:0]      rdb_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_q  <= '0;
        rdb_q <= '0;
      end else begin
        rd_q  <= rd_v;
        rdb_q <= b_v;
      end
    end

    assign bus.rd      = rd_q;
    assign bus.rd_busy = rdb_q;
  end else begin : g_comb
    // Bypass could otherwise leak write data while reset is held.
    assign bus.rd      = rst ? rd_v : '0;
    assign bus.rd_busy = rst ? b_v : '0;
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: a combinational-read instance (NRD=2) and a registered-read
// instance (NRD=3) share write/issue stimulus and are checked against an array model.
module tb_register_file_sb;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        issue_v;
  logic [4:0]  issue_a;
  logic [9:0]  ra_a;
  logic [14:0] ra_b;

  int checks = 0;
  int errors = 0;

  register_file_sb_if #(.XLEN(32), .AW(5), .NRD(2)) ifa ();
  register_file_sb_if #(.XLEN(32), .AW(5), .NRD(3)) ifb ();

  assign ifa.ra = ra_a;      assign ifb.ra = ra_b;
  assign ifa.we = we;        assign ifb.we = we;
  assign ifa.wa = wa;        assign ifb.wa = wa;
  assign ifa.wd = wd;        assign ifb.wd = wd;
  assign ifa.issue_v = issue_v;  assign ifb.issue_v = issue_v;
  assign ifa.issue_a = issue_a;  assign ifb.issue_a = issue_a;

  register_file_sb #(
    .XLEN(32), .NREG(32), .AW(5), .NRD(2), .ZERO_REG(1), .BYPASS(1), .READ_REG(0)
  ) u_dut_a (
    .clk(clk),
    .rst(rst),
    .bus(ifa)
  );

  register_file_sb #(
    .XLEN(32), .NREG(32), .AW(5), .NRD(3), .ZERO_REG(1), .BYPASS(1), .READ_REG(1)
  ) u_dut_b (
    .clk(clk),
    .rst(rst),
    .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model: register contents, pending-producer set, and the registered
  // view that the READ_REG instance must show one cycle later.
  logic [31:0] mreg [32];
  logic [31:0] mbusy;
  logic [31:0] expb_d [3];
  logic [2:0]  expb_b;

  function automatic logic [31:0] mval(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return mreg[a];
  endfunction

  function automatic logic mbsy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (we && wa == a) return issue_v && issue_a == a;
    return mbusy[a];
  endfunction

  initial begin
    for (int r = 0; r < 32; r++) mreg[r] = 32'd0;
    mbusy  = 32'd0;
    expb_b = 3'd0;
    for (int p = 0; p < 3; p++) expb_d[p] = 32'd0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int r = 0; r < 32; r++) mreg[r] = 32'd0;
        mbusy  = 32'd0;
        expb_b = 3'd0;
        for (int p = 0; p < 3; p++) expb_d[p] = 32'd0;
      end else if (clk) begin
        for (int p = 0; p < 3; p++) begin
          expb_d[p] = mval(ra_b[p*5 +: 5]);
          expb_b[p] = mbsy(ra_b[p*5 +: 5]);
        end
        if (we && wa != 5'd0) mreg[wa] = wd;
        if (we) mbusy[wa] = 1'b0;
        if (issue_v && issue_a != 5'd0) mbusy[issue_a] = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        check($sformatf("model_a_rd%0d", p), ifa.rd[p*32 +: 32],
              rst ? mval(ra_a[p*5 +: 5]) : 32'd0);
        check($sformatf("model_a_busy%0d", p), {31'd0, ifa.rd_busy[p]},
              {31'd0, rst ? mbsy(ra_a[p*5 +: 5]) : 1'b0});
      end
      for (int p = 0; p < 3; p++) begin
        check($sformatf("model_b_rd%0d", p), ifb.rd[p*32 +: 32], expb_d[p]);
        check($sformatf("model_b_busy%0d", p), {31'd0, ifb.rd_busy[p]}, {31'd0, expb_b[p]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_a(input string name, input int p, input logic [31:0] d, input logic b);
    check({name, "_rd"}, ifa.rd[p*32 +: 32], d);
    check({name, "_busy"}, {31'd0, ifa.rd_busy[p]}, {31'd0, b});
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; wa = '0; wd = '0; issue_v = 1'b0; issue_a = '0;
    ra_a = '0; ra_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Preload x5=6 (also claimed busy) and x6=0xA.
    we = 1'b1; wa = 5'd5; wd = 32'd6; issue_v = 1'b1; issue_a = 5'd5;
    step();
    wa = 5'd6; wd = 32'hA; issue_v = 1'b0;
    step();
    we = 1'b0;
    ra_a = {5'd6, 5'd5};
    ra_b = {5'd6, 5'd5, 5'd0};
    mid();
    chk_a("pre_x5", 0, 32'd6, 1'b1);
    chk_a("pre_x6", 1, 32'hA, 1'b0);

    // Registered reads: ra captured at the edge, data visible this cycle.
    @(posedge clk);
    mid();
    check("rreg_p2", ifb.rd[64 +: 32], 32'hA);
    check("rreg_p1", ifb.rd[32 +: 32], 32'd6);
    check("rreg_p0", ifb.rd[0 +: 32], 32'd0);
    check("rreg_busy", {29'd0, ifb.rd_busy}, 32'b010);

    // Asynchronous reset mid-cycle with a write in flight.
    we = 1'b1; wa = 5'd5; wd = 32'h77;
    #1 rst = 1'b0;
    #1;
    chk_a("rst_p0", 0, 32'd0, 1'b0);
    chk_a("rst_p1", 1, 32'd0, 1'b0);
    check("rst_b_rd", ifb.rd[0 +: 32] | ifb.rd[32 +: 32] | ifb.rd[64 +: 32], 32'd0);
    check("rst_b_busy", {29'd0, ifb.rd_busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1; we = 1'b0;
    mid();
    chk_a("lost_write", 0, 32'd0, 1'b0);

    // Restore x5=6, then hit x0 with a write and an issue.
    we = 1'b1; wa = 5'd5; wd = 32'd6;
    step();
    wa = 5'd0; wd = 32'hDEADBEEF; issue_v = 1'b1; issue_a = 5'd0;
    ra_a = {5'd0, 5'd0};
    ra_b = {5'd5, 5'd0, 5'd0};
    mid();
    chk_a("x0_same", 0, 32'd0, 1'b0);
    step();
    we = 1'b0; issue_v = 1'b0;
    mid();
    chk_a("x0_after", 1, 32'd0, 1'b0);

    // Bypass: both ports see the in-flight write.
    we = 1'b1; wa = 5'd5; wd = 32'h10;
    ra_a = {5'd5, 5'd5};
    mid();
    chk_a("byp_p0", 0, 32'h10, 1'b0);
    chk_a("byp_p1", 1, 32'h10, 1'b0);
    step();
    we = 1'b0;
    mid();
    chk_a("byp_stored", 0, 32'h10, 1'b0);

    // Scoreboard claim, then release by write.
    issue_v = 1'b1; issue_a = 5'd7;
    ra_a = {5'd7, 5'd7};
    ra_b = {5'd7, 5'd7, 5'd5};
    step();
    issue_v = 1'b0;
    mid();
    chk_a("sb_claim", 0, 32'd0, 1'b1);
    step();
    we = 1'b1; wa = 5'd7; wd = 32'd3;
    mid();
    chk_a("sb_wr_same", 0, 32'd3, 1'b0);
    step();
    we = 1'b0;
    mid();
    chk_a("sb_wr_after", 1, 32'd3, 1'b0);

    // Set/clear collision: new producer keeps the register busy.
    issue_v = 1'b1; issue_a = 5'd7;
    step();
    we = 1'b1; wa = 5'd7; wd = 32'h55;
    mid();
    chk_a("coll_same", 0, 32'h55, 1'b1);
    step();
    we = 1'b0; issue_v = 1'b0;
    mid();
    chk_a("coll_after", 0, 32'h55, 1'b1);

    // Short sweep of mixed writes, issues and reads; model comparisons only.
    for (int r = 1; r <= 8; r++) begin
      we = (r % 3) != 0; wa = 5'(r + 8); wd = 32'(r) * 32'h1111_0101;
      issue_v = (r % 2) == 0; issue_a = 5'(r + 7);
      ra_a = {5'(r + 7), 5'(r + 8)};
      ra_b = {5'(r + 8), 5'(r + 7), 5'(r + 6)};
      step();
    end
    we = 1'b0; issue_v = 1'b0;
    for (int r = 0; r < 4; r++) begin
      ra_a = {5'(r * 2 + 9), 5'(r * 2 + 10)};
      ra_b = {5'(r + 9), 5'(r + 12), 5'(r + 14)};
      step();
    end
    mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
